// File: rtl/btb_pkg.sv
// btb_pkg: shared sizing helpers and constants for the branch target buffer
package btb_pkg;
  localparam int PC_INC = 4;
  function automatic int idx_w(input int entries);
    return $clog2(entries);
  endfunction
  function automatic int tag_w(input int addr_w, input int entries);
    return addr_w - $clog2(entries) - 2;
  endfunction
  function automatic int ctr_weak_nt(input int w);
    return (1 << (w - 1)) - 1;
  endfunction
  function automatic int ctr_weak_t(input int w);
    return 1 << (w - 1);
  endfunction
endpackage

// File: rtl/sat_counter.sv
// sat_counter: up/down counter saturating at 0 and all-ones, with parallel load
module sat_counter #(
  parameter int W = 2,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic         inc,
  input  logic         dec,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] q
);
  // load wins over counting; counting stops at either end of the range
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) q <= RST_VAL;
    else if (en) q <= load ? load_val : (inc && !(&q)) ? q + 1'b1 : (dec && |q) ? q - 1'b1 : q;
endmodule

// File: rtl/btb_predictor.sv
// btb_predictor: direct-mapped BTB with per-entry saturating direction counters
module btb_predictor
  import btb_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int ENTRIES = 16,
  parameter int CTR_W = 2,
  parameter int STAT_W = 16
) (
  input  logic              Clk,
  input  logic              Clrn,
  input  logic              En,
  input  logic              Inv,
  input  logic [ADDR_W-1:0] IF_Addr,
  output logic              Pred_Taken,
  output logic [ADDR_W-1:0] Pred_Target,
  input  logic              Upd_Valid,
  input  logic [ADDR_W-1:0] Upd_PC,
  input  logic              Upd_Taken,
  input  logic [ADDR_W-1:0] Upd_Target,
  input  logic              Upd_PredTaken,
  input  logic [ADDR_W-1:0] Upd_PredTarget,
  output logic              Flush,
  output logic [ADDR_W-1:0] Flush_PC,
  output logic [STAT_W-1:0] Stat_Branches,
  output logic [STAT_W-1:0] Stat_Mispred
);
  localparam int IDX_W = idx_w(ENTRIES);
  localparam int TAG_W = tag_w(ADDR_W, ENTRIES);
  localparam logic [CTR_W-1:0] CTR_WEAK_NT = CTR_W'(ctr_weak_nt(CTR_W));
  localparam logic [CTR_W-1:0] CTR_WEAK_T = CTR_W'(ctr_weak_t(CTR_W));
  localparam logic [ADDR_W-1:0] INC = ADDR_W'(PC_INC);
  logic [ENTRIES-1:0] valid;
  logic [TAG_W-1:0]   tags [ENTRIES];
  logic [ADDR_W-1:0]  targets [ENTRIES];
  logic [CTR_W-1:0]   ctr [ENTRIES];
  logic [IDX_W-1:0]   l_idx, u_idx;
  logic [TAG_W-1:0]   l_tag, u_tag;
  logic               l_hit, u_hit, upd;
  assign l_idx = IF_Addr[IDX_W+1:2];
  assign l_tag = IF_Addr[ADDR_W-1:IDX_W+2];
  assign u_idx = Upd_PC[IDX_W+1:2];
  assign u_tag = Upd_PC[ADDR_W-1:IDX_W+2];
  assign l_hit = valid[l_idx] && tags[l_idx] == l_tag;
  assign u_hit = valid[u_idx] && tags[u_idx] == u_tag;
  assign upd = En && Upd_Valid && !Inv;
  assign Pred_Taken = l_hit && ctr[l_idx][CTR_W-1];
  assign Pred_Target = Pred_Taken ? targets[l_idx] : IF_Addr + INC;
  assign Flush = Upd_Valid && (Upd_Taken != Upd_PredTaken || (Upd_Taken && Upd_Target != Upd_PredTarget));
  assign Flush_PC = Upd_Taken ? Upd_Target : Upd_PC + INC;
  // a taken update either refreshes a hit entry or allocates over the indexed one;
  // invalidate clears only valid bits and beats a same-cycle update
  always_ff @(posedge Clk or negedge Clrn)
    if (!Clrn) begin
      valid <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        tags[i] <= '0;
        targets[i] <= '0;
      end
    end else if (En && Inv) valid <= '0;
    else if (upd && Upd_Taken) begin
      valid[u_idx] <= 1'b1;
      tags[u_idx] <= u_tag;
      targets[u_idx] <= Upd_Target;
    end
  for (genvar i = 0; i < ENTRIES; i++) begin : g_ctr
    sat_counter #(.W(CTR_W), .RST_VAL(CTR_WEAK_NT)) u_ctr (
      .clk(Clk), .rst_n(Clrn), .en(upd && u_idx == IDX_W'(i)),
      .inc(u_hit && Upd_Taken), .dec(u_hit && !Upd_Taken),
      .load(!u_hit && Upd_Taken), .load_val(CTR_WEAK_T), .q(ctr[i])
    );
  end
  sat_counter #(.W(STAT_W)) u_stat_br (
    .clk(Clk), .rst_n(Clrn), .en(En), .inc(Upd_Valid), .dec(1'b0),
    .load(1'b0), .load_val('0), .q(Stat_Branches)
  );
  sat_counter #(.W(STAT_W)) u_stat_mp (
    .clk(Clk), .rst_n(Clrn), .en(En), .inc(Flush), .dec(1'b0),
    .load(1'b0), .load_val('0), .q(Stat_Mispred)
  );
endmodule

// File: tb/tb_btb_predictor.sv
// tb_btb_predictor: randomized scoreboard bench against a behavioural BTB model
module tb_btb_predictor;
  localparam int AW = 32;
  localparam int SW = 2;
  localparam int STAT_MAX = (1 << SW) - 1;
  logic Clk = 0, Clrn = 0, En = 0, Inv = 0;
  logic [AW-1:0] IF_Addr = 0, Upd_PC = 0, Upd_Target = 0, Upd_PredTarget = 0;
  logic Upd_Valid = 0, Upd_Taken = 0, Upd_PredTaken = 0;
  logic Pred_Taken, Flush;
  logic [AW-1:0] Pred_Target, Flush_PC;
  logic [SW-1:0] Stat_Branches, Stat_Mispred;
  int checks = 0, errors = 0;

  btb_predictor #(.ADDR_W(AW), .ENTRIES(16), .CTR_W(2), .STAT_W(SW)) dut (
    .Clk(Clk), .Clrn(Clrn), .En(En), .Inv(Inv), .IF_Addr(IF_Addr),
    .Pred_Taken(Pred_Taken), .Pred_Target(Pred_Target), .Upd_Valid(Upd_Valid),
    .Upd_PC(Upd_PC), .Upd_Taken(Upd_Taken), .Upd_Target(Upd_Target),
    .Upd_PredTaken(Upd_PredTaken), .Upd_PredTarget(Upd_PredTarget),
    .Flush(Flush), .Flush_PC(Flush_PC), .Stat_Branches(Stat_Branches), .Stat_Mispred(Stat_Mispred)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    string nm;
    bit pt;
    logic [AW-1:0] ptg;
    bit fl;
    logic [AW-1:0] fpc;
    int sb;
    int sm;
  } exp_t;
  exp_t sb_q[$];

  bit m_valid[16];
  int unsigned m_tag[16];
  logic [AW-1:0] m_tgt[16];
  int m_ctr[16];
  int m_sb, m_sm;

  function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endfunction

  function automatic void m_reset();
    for (int i = 0; i < 16; i++) begin
      m_valid[i] = 0;
      m_tag[i] = 0;
      m_tgt[i] = 0;
      m_ctr[i] = 1;
    end
    m_sb = 0;
    m_sm = 0;
  endfunction

  function automatic void m_look(input logic [AW-1:0] a, output bit pt, output logic [AW-1:0] tg, output bit hit);
    int i;
    i = int'((a >> 2) % 16);
    hit = m_valid[i] && m_tag[i] == (a >> 6);
    pt = hit && m_ctr[i] >= 2;
    tg = pt ? m_tgt[i] : a + 32'd4;
  endfunction

  // drive one cycle, predict the DUT's response, then advance the model past the edge
  task automatic step(input bit en, input bit inv, input logic [AW-1:0] a, input bit uv,
                      input logic [AW-1:0] upc, input bit ut, input logic [AW-1:0] utg,
                      input bit upt, input logic [AW-1:0] uptg, input string nm);
    exp_t e;
    bit h, uh, dpt;
    logic [AW-1:0] dtg;
    int i;
    En = en; Inv = inv; IF_Addr = a; Upd_Valid = uv; Upd_PC = upc; Upd_Taken = ut;
    Upd_Target = utg; Upd_PredTaken = upt; Upd_PredTarget = uptg;
    e.nm = nm;
    m_look(a, e.pt, e.ptg, h);
    e.fl = uv && (ut != upt || (ut && utg != uptg));
    e.fpc = ut ? utg : upc + 32'd4;
    e.sb = m_sb;
    e.sm = m_sm;
    sb_q.push_back(e);
    if (en) begin
      m_sb = (m_sb + int'(uv) > STAT_MAX) ? STAT_MAX : m_sb + int'(uv);
      m_sm = (m_sm + int'(e.fl) > STAT_MAX) ? STAT_MAX : m_sm + int'(e.fl);
      if (inv) for (int k = 0; k < 16; k++) m_valid[k] = 0;
      else if (uv) begin
        m_look(upc, dpt, dtg, uh);
        i = int'((upc >> 2) % 16);
        if (uh) begin
          m_ctr[i] = ut ? (m_ctr[i] == 3 ? 3 : m_ctr[i] + 1) : (m_ctr[i] == 0 ? 0 : m_ctr[i] - 1);
          if (ut) m_tgt[i] = utg;
        end else if (ut) begin
          m_valid[i] = 1;
          m_tag[i] = upc >> 6;
          m_tgt[i] = utg;
          m_ctr[i] = 2;
        end
      end
    end
    @(posedge Clk);
    #1;
  endtask

  task automatic look(input logic [AW-1:0] a, input string nm);
    step(1, 0, a, 0, 0, 0, 0, 0, 0, nm);
  endtask

  task automatic train(input logic [AW-1:0] pc, input bit ut, input logic [AW-1:0] utg, input string nm);
    bit pt, h;
    logic [AW-1:0] tg;
    m_look(pc, pt, tg, h);
    step(1, 0, pc, 1, pc, ut, utg, pt, tg, nm);
  endtask

  // monitor: outputs are presented every cycle, so each expected entry is checked mid-cycle
  always @(negedge Clk) begin
    exp_t e;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      chk({e.nm, " pred_taken"}, 64'(Pred_Taken), 64'(e.pt));
      chk({e.nm, " pred_target"}, 64'(Pred_Target), 64'(e.ptg));
      chk({e.nm, " flush"}, 64'(Flush), 64'(e.fl));
      if (e.fl) chk({e.nm, " flush_pc"}, 64'(Flush_PC), 64'(e.fpc));
      chk({e.nm, " stat_branches"}, 64'(Stat_Branches), 64'(e.sb));
      chk({e.nm, " stat_mispred"}, 64'(Stat_Mispred), 64'(e.sm));
    end
  end

  function automatic logic [AW-1:0] rnd_addr();
    return AW'(($urandom_range(0, 3) << 6) | ($urandom_range(0, 3) << 2) | $urandom_range(0, 3));
  endfunction

  initial begin
    bit pt, h;
    logic [AW-1:0] tg, a, utg;
    m_reset();
    IF_Addr = 32'h40;
    #3;
    chk("reset pred_taken", 64'(Pred_Taken), 0);
    chk("reset pred_target", 64'(Pred_Target), 64'h44);
    chk("reset stats", 64'({Stat_Branches, Stat_Mispred}), 0);
    @(posedge Clk);
    #1;
    Clrn = 1;
    look(32'h40, "empty lookup");
    step(1, 0, 32'h40, 1, 32'h40, 1, 32'h100, 0, 32'h44, "first taken");
    look(32'h40, "trained lookup");
    step(1, 0, 32'h40, 1, 32'h80, 1, 32'h200, 0, 32'h84, "alias alloc");
    look(32'h40, "alias evicted");
    look(32'h80, "alias hit");
    train(32'h40, 1, 32'h100, "hyst t1");
    train(32'h40, 1, 32'h100, "hyst t2");
    train(32'h40, 0, 32'h0, "hyst nt1");
    look(32'h40, "hyst still taken");
    train(32'h40, 0, 32'h0, "hyst nt2");
    look(32'h40, "hyst not taken");
    train(32'h44, 1, 32'h300, "alloc 44");
    step(1, 1, 32'h44, 1, 32'h48, 1, 32'h400, 0, 32'h4c, "inv with update");
    look(32'h44, "after inv");
    look(32'h48, "inv beat update");
    step(0, 0, 32'h48, 1, 32'h48, 1, 32'h500, 0, 32'h4c, "disabled update");
    look(32'h48, "disabled no alloc");
    repeat (400) begin
      a = rnd_addr();
      utg = AW'($urandom_range(0, 255) << 2);
      if ($urandom_range(0, 1)) m_look(a, pt, tg, h);
      else begin
        pt = 1'($urandom);
        tg = AW'($urandom_range(0, 255) << 2);
      end
      step($urandom_range(0, 9) != 0, $urandom_range(0, 24) == 0, rnd_addr(), 1'($urandom),
           a, 1'($urandom), utg, pt, tg, "random");
    end
    train(32'hc0, 1, 32'h600, "pre-reset alloc");
    IF_Addr = 32'hc0;
    Upd_Valid = 1; Upd_PC = 32'hc0; Upd_Taken = 1; Upd_Target = 32'h600; Upd_PredTaken = 0;
    Clrn = 0;
    #2;
    chk("async reset pred_taken", 64'(Pred_Taken), 0);
    chk("async reset pred_target", 64'(Pred_Target), 64'hc4);
    chk("async reset stats", 64'({Stat_Branches, Stat_Mispred}), 0);
    chk("async reset flush live", 64'(Flush), 1);
    @(posedge Clk);
    #1;
    Clrn = 1;
    m_reset();
    look(32'hc0, "post reset lookup");
    repeat (3) step(1, 0, 32'h0, 1, 32'h10, 1, 32'h20, 0, 32'h14, "sat mispred");
    look(32'h10, "sat hit");
    repeat (2) step(1, 0, 32'h0, 1, 32'h10, 0, 32'h0, 1, 32'h20, "sat more");
    look(32'h0, "sat final");
    chk("stat_mispred saturated", 64'(Stat_Mispred), 3);
    repeat (3) @(negedge Clk);
    if (sb_q.size() != 0) chk("scoreboard drained", 64'(sb_q.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/btb_predictor.md
# btb_predictor

- Parametrised branch target buffer with saturating-counter direction predictor.
- Sits beside the PC in the IF stage of the pipelined CPU: supplies a predicted next-fetch address every cycle.
- Trained by the resolved branch/jump in EX; raises a flush with the corrected PC when the prediction carried down the pipe was wrong.
- Replaces the fixed resolve-in-EX, always-not-taken redirect path; adds saturating statistics counters for branches and mispredicts.

## Interface

Parameters:
- ADDR_W, 32: address/PC width; must be > IDX_W+2.
- ENTRIES, 16: table depth; power of two, ≥2. IDX_W = log2(ENTRIES).
- CTR_W, 2: direction counter width, ≥1.
- STAT_W, 16: statistics counter width.

Ports:
- Clk  in  1  clock; all state changes on rising edge.
- Clrn  in  1  asynchronous, active-low reset.
- En  in  1  global enable; 0 freezes table, stats and invalidate.
- Inv  in  1  synchronous invalidate of all entries.
- IF_Addr  in  ADDR_W  current fetch PC.
- Pred_Taken  out  1  lookup hit with counter MSB=1.
- Pred_Target  out  ADDR_W  stored target if Pred_Taken, else IF_Addr+4.
- Upd_Valid  in  1  EX holds a resolved branch/jump this cycle.
- Upd_PC  in  ADDR_W  PC of the resolved instruction.
- Upd_Taken  in  1  actual direction.
- Upd_Target  in  ADDR_W  actual taken target.
- Upd_PredTaken  in  1  Pred_Taken as captured at fetch, piped to EX.
- Upd_PredTarget  in  ADDR_W  Pred_Target as captured at fetch.
- Flush  out  1  mispredict; kill IF/ID and ID/EX, load Flush_PC.
- Flush_PC  out  ADDR_W  corrected next PC.
- Stat_Branches  out  STAT_W  resolved-branch count.
- Stat_Mispred  out  STAT_W  mispredict count.

## Operation

- Address split: index = addr[IDX_W+1:2]; tag = addr[ADDR_W-1:IDX_W+2]. Bits [1:0] are ignored.
- Entry fields: valid, tag, target[ADDR_W], ctr[CTR_W].
- Lookup (combinational):
  - hit = valid & tag match.
  - Pred_Taken = hit & ctr[MSB].
  - Pred_Target = Pred_Taken ? target : IF_Addr+4, modulo 2^ADDR_W.
- Flush (combinational) = Upd_Valid & ((Upd_Taken != Upd_PredTaken) | (Upd_Taken & Upd_Target != Upd_PredTarget)).
- Flush_PC = Upd_Taken ? Upd_Target : Upd_PC+4, modulo 2^ADDR_W.
- Flush and Flush_PC are not gated by En.
- Update, on rising edge when En & Upd_Valid & !Inv:
  - Upd_PC hits: ctr saturating +1 if taken, −1 if not; target := Upd_Target if taken.
  - Upd_PC misses and taken: allocate/overwrite the indexed entry: valid=1, tag, target, ctr = 2^(CTR_W-1) (weakly taken).
  - Upd_PC misses and not taken: no change.
- Inv, when En: all valid := 0; ctr and target untouched. Inv takes priority over a same-cycle update.
- Stats, when En:
  - Stat_Branches +1 per Upd_Valid.
  - Stat_Mispred +1 per Flush.
  - Both saturate at all-ones. Cleared only by Clrn; Inv does not clear them.

## Timing

- Reset (Clrn=0, asynchronous): all valid=0, ctr=2^(CTR_W-1)-1, target=0, stats=0.
  - Outputs during reset: Pred_Taken=0, Pred_Target=IF_Addr+4, Stat_*=0.
  - Flush stays combinational from its inputs.
- Lookup latency: 0 cycles.
- Update visibility: 1 cycle. A lookup at the same index in the update cycle sees the old entry; no bypass.
- Flush is valid in the same cycle as Upd_Valid. The CPU loads Flush_PC at the next edge.
- Reset mid-operation: in-flight update is lost; table restarts empty.
- En=0 with Upd_Valid=1: Flush still asserted; table and stats unchanged.

## Structure

- Shared package `btb_pkg`:
  - idx_w/tag_w functions from parameters.
  - Counter init constants CTR_WEAK_NT and CTR_WEAK_T.
  - PC increment constant 4.
- Sub-module `sat_counter`: parametrised width; inc/dec/hold; saturates at 0 and all-ones. Used for each entry's ctr and for both stat counters.
- Table: register array. No memory macro, because lookup is asynchronous.

## Test plan

Defaults: ENTRIES=16, CTR_W=2, ADDR_W=32.

- Reset, then IF_Addr=0x40 → Pred_Taken=0, Pred_Target=0x44, stats 0.
- Upd PC=0x40, taken, target 0x100, PredTaken=0 → Flush=1, Flush_PC=0x100, Stat_Mispred=1. Next cycle IF_Addr=0x40 → Pred_Taken=1, Pred_Target=0x100.
- Aliasing: 0x40 trained taken, then update PC=0x80 (same index, tag 2), taken, target 0x200 → lookup 0x40 misses (Pred_Target=0x44); lookup 0x80 gives 0x200.
- Hysteresis: 0x40 trained taken twice (ctr=3), then not-taken once → still predicts taken. A second not-taken → predicts not taken.
- Inv=1 together with Upd_Valid=1 → all lookups miss next cycle; Stat_Branches still increments.
- STAT_W=2, 5 mispredicts → Stat_Mispred=3. Clrn pulse mid-stream → all stats 0 and table empty immediately, without waiting for a clock edge.
